// File: rtl/pwr_switch_model_pkg.sv
// Shared types and sizing helpers for the power-switch acknowledge model.
package pwr_switch_model_pkg;

    typedef enum logic [1:0] {
        OFF      = 2'd0,
        RAMP_ON  = 2'd1,
        ON       = 2'd2,
        RAMP_OFF = 2'd3
    } sw_state_e;

    localparam int ABORT_CNT_W = 8;

    // Ramp counter must hold the larger of the two latencies minus one.
    function automatic int cnt_width(input int on_lat, input int off_lat);
        int m;
        m = (on_lat > off_lat) ? on_lat : off_lat;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pwr_switch_chan.sv
// One power-switch channel: ramp FSM, programmable latency counter and
// saturating abort counter.
module pwr_switch_chan
    import pwr_switch_model_pkg::*;
#(
    parameter int   ON_LATENCY  = 15,
    parameter int   OFF_LATENCY = 15,
    parameter logic RESET_ON    = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   switch_n_i,
    input  logic                   stall_i,
    output logic                   ack_n_o,
    output logic                   busy_o,
    output logic [ABORT_CNT_W-1:0] abort_cnt_o
);

    localparam int CW = cnt_width(ON_LATENCY, OFF_LATENCY);

    sw_state_e              state_reg, state_next;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   ack_reg, ack_next;
    logic                   busy_reg, busy_next;
    logic [ABORT_CNT_W-1:0] abort_reg, abort_next;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= RESET_ON ? ON : OFF;
            cnt_reg   <= '0;
            ack_reg   <= ~RESET_ON;
            busy_reg  <= 1'b0;
            abort_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            busy_reg  <= busy_next;
            abort_reg <= abort_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = ack_reg;
        busy_next  = busy_reg;
        abort_next = abort_reg;
        case (state_reg)
            OFF: begin
                if (!switch_n_i) begin
                    state_next = RAMP_ON;
                    cnt_next   = CW'(ON_LATENCY - 1);
                    busy_next  = 1'b1;
                end
            end
            ON: begin
                if (switch_n_i) begin
                    state_next = RAMP_OFF;
                    cnt_next   = CW'(OFF_LATENCY - 1);
                    busy_next  = 1'b1;
                end
            end
            RAMP_ON: begin
                // A reversal wins over a stall.
                if (switch_n_i) begin
                    state_next = OFF;
                    busy_next  = 1'b0;
                    if (abort_reg != '1) abort_next = abort_reg + ABORT_CNT_W'(1);
                end else if (!stall_i) begin
                    if (cnt_reg == '0) begin
                        state_next = ON;
                        ack_next   = ~ack_reg;
                        busy_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
            end
            RAMP_OFF: begin
                if (!switch_n_i) begin
                    state_next = ON;
                    busy_next  = 1'b0;
                    if (abort_reg != '1) abort_next = abort_reg + ABORT_CNT_W'(1);
                end else if (!stall_i) begin
                    if (cnt_reg == '0) begin
                        state_next = OFF;
                        ack_next   = ~ack_reg;
                        busy_next  = 1'b0;
                    end else begin
                        cnt_next = cnt_reg - CW'(1);
                    end
                end
            end
            default: state_next = OFF;
        endcase
    end

    assign ack_n_o     = ack_reg;
    assign busy_o      = busy_reg;
    assign abort_cnt_o = abort_reg;

endmodule

// File: rtl/pwr_switch_ack_model.sv
// Power-switch acknowledge model: NUM_DOMAINS independent channels whose
// active-low acks follow the switch requests after programmable latencies.
module pwr_switch_ack_model
    import pwr_switch_model_pkg::*;
#(
    parameter int   NUM_DOMAINS = 4,
    parameter int   ON_LATENCY  = 15,
    parameter int   OFF_LATENCY = 15,
    parameter logic RESET_ON    = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_DOMAINS-1:0]             switch_n_i,
    input  logic [NUM_DOMAINS-1:0]             stall_i,
    output logic [NUM_DOMAINS-1:0]             ack_n_o,
    output logic [NUM_DOMAINS-1:0]             busy_o,
    output logic [NUM_DOMAINS*ABORT_CNT_W-1:0] abort_cnt_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_chan
            pwr_switch_chan #(
                .ON_LATENCY (ON_LATENCY),
                .OFF_LATENCY(OFF_LATENCY),
                .RESET_ON   (RESET_ON)
            ) u_chan (
                .clk_i      (clk_i),
                .rst_ni     (rst_ni),
                .switch_n_i (switch_n_i[gi]),
                .stall_i    (stall_i[gi]),
                .ack_n_o    (ack_n_o[gi]),
                .busy_o     (busy_o[gi]),
                .abort_cnt_o(abort_cnt_o[gi*ABORT_CNT_W +: ABORT_CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwr_switch_ack_model.sv
// Scoreboard bench for pwr_switch_ack_model: two configurations driven by
// directed and random requests, checked against a deadline-based reference.
module tb_pwr_switch_ack_model;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  sw_a = 4'h0, st_a = 4'h0, sw_b = 4'hF, st_b = 4'h0;
    logic [3:0]  ack_a, busy_a, ack_b, busy_b;
    logic [31:0] abort_a, abort_b;

    always #5 clk = ~clk;

    pwr_switch_ack_model #(.NUM_DOMAINS(4), .ON_LATENCY(3), .OFF_LATENCY(7), .RESET_ON(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_a), .stall_i(st_a),
        .ack_n_o(ack_a), .busy_o(busy_a), .abort_cnt_o(abort_a));

    pwr_switch_ack_model #(.NUM_DOMAINS(4), .ON_LATENCY(15), .OFF_LATENCY(1), .RESET_ON(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_b), .stall_i(st_b),
        .ack_n_o(ack_b), .busy_o(busy_b), .abort_cnt_o(abort_b));

    // Reference: a ramp is a deadline edge number, pushed out by each stall.
    int on_lat [2] = '{3, 15};
    int off_lat[2] = '{7, 1};
    bit rst_on [2] = '{1'b1, 1'b0};
    bit powered [2][4];
    bit ramping [2][4];
    int deadline[2][4];
    int aborts  [2][4];
    int edge_no = 0;

    typedef struct {
        int          inst;
        int          edge_no;
        logic [3:0]  ack;
        logic [3:0]  busy;
        logic [31:0] abort;
    } snap_t;
    snap_t exp_q[$];

    int checks = 0;
    int passed = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 4; c++) begin
                powered[i][c] = rst_on[i];
                ramping[i][c] = 1'b0;
                deadline[i][c] = 0;
                aborts[i][c] = 0;
            end
    endtask

    task automatic model_edge();
        logic [3:0] swv, stv;
        bit want_on;
        for (int i = 0; i < 2; i++) begin
            swv = (i == 0) ? sw_a : sw_b;
            stv = (i == 0) ? st_a : st_b;
            for (int c = 0; c < 4; c++) begin
                want_on = !swv[c];
                if (!ramping[i][c]) begin
                    if (want_on != powered[i][c]) begin
                        ramping[i][c] = 1'b1;
                        deadline[i][c] = edge_no + (want_on ? on_lat[i] : off_lat[i]);
                    end
                end else if (want_on == powered[i][c]) begin
                    ramping[i][c] = 1'b0;
                    aborts[i][c] = (aborts[i][c] < 255) ? aborts[i][c] + 1 : 255;
                end else if (stv[c]) begin
                    deadline[i][c]++;
                end else if (edge_no == deadline[i][c]) begin
                    powered[i][c] = want_on;
                    ramping[i][c] = 1'b0;
                end
            end
        end
    endtask

    task automatic push_all();
        snap_t s;
        for (int i = 0; i < 2; i++) begin
            s.inst = i;
            s.edge_no = edge_no;
            for (int c = 0; c < 4; c++) begin
                s.ack[c] = !powered[i][c];
                s.busy[c] = ramping[i][c];
                s.abort[c*8 +: 8] = 8'(aborts[i][c]);
            end
            exp_q.push_back(s);
        end
    endtask

    // Reset pulse goes low 2 units after the edge, so the following negedge
    // sample can only see reset values if the reset acts asynchronously.
    task automatic tick(input bit rst_pulse);
        @(posedge clk);
        edge_no++;
        if (rst_pulse) begin
            model_reset();
            push_all();
            #2 rst_n = 1'b0;
            #5 rst_n = 1'b1;
        end else begin
            model_edge();
            push_all();
            #2;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(1'b0);
    endtask

    task automatic chk(input string name, input int inst, input int e,
                       input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v)
            $display("FAIL %s dut%0d edge %0d: got %h expected %h", name, inst, e, act, exp_v);
        else
            passed++;
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                if (s.inst == 0) begin
                    chk("ack", 0, s.edge_no, {28'h0, ack_a}, {28'h0, s.ack});
                    chk("busy", 0, s.edge_no, {28'h0, busy_a}, {28'h0, s.busy});
                    chk("abort_cnt", 0, s.edge_no, abort_a, s.abort);
                end else begin
                    chk("ack", 1, s.edge_no, {28'h0, ack_b}, {28'h0, s.ack});
                    chk("busy", 1, s.edge_no, {28'h0, busy_b}, {28'h0, s.busy});
                    chk("abort_cnt", 1, s.edge_no, abort_b, s.abort);
                end
            end
        end
    end

    initial begin : stimulus
        model_reset();
        tick(1'b1);
        ticks(3);

        // Power-down then power-up of one domain, distinct latencies.
        sw_a[2] = 1'b1; ticks(20);
        sw_a[2] = 1'b0; ticks(20);

        // Sub-cycle glitch between edges must be ignored.
        sw_a[0] = 1'b1; #3 sw_a[0] = 1'b0;
        ticks(3);

        // Five stall cycles in the middle of a 15-cycle power-up.
        sw_b[0] = 1'b0; ticks(4);
        st_b[0] = 1'b1; ticks(5);
        st_b[0] = 1'b0; ticks(20);

        // Single-cycle power-down latency.
        sw_b[0] = 1'b1; ticks(3);

        // Reversal while stalled still aborts.
        sw_b[1] = 1'b0; ticks(3);
        st_b[1] = 1'b1; sw_b[1] = 1'b1; ticks(1);
        st_b[1] = 1'b0; ticks(3);

        // Reset mid-ramp; the still-active request restarts a full ramp.
        sw_b[3] = 1'b0; sw_a[3] = 1'b1; ticks(8);
        tick(1'b1);
        ticks(20);
        sw_a[3] = 1'b0; ticks(10);

        // Repeated aborted power-downs until the abort counter saturates.
        repeat (300) begin
            sw_a[1] = 1'b1; ticks(4);
            sw_a[1] = 1'b0; ticks(1);
        end
        ticks(3);

        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(7) == 0) sw_a[c] = ~sw_a[c];
                if ($urandom_range(7) == 0) sw_b[c] = ~sw_b[c];
                st_a[c] = ($urandom_range(5) == 0);
                st_b[c] = ($urandom_range(5) == 0);
            end
            tick($urandom_range(299) == 0);
        end
        st_a = 4'h0; st_b = 4'h0;
        ticks(20);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pwr_switch_ack_model.md
# pwr_switch_ack_model

Parametrised behavioural-synthesisable model of power-switch cells for the simulation testharness. For each power domain (CPU, peripheral, memory banks, external domains) it returns the acknowledge that real header switches would give. The ack follows the switch request after a programmable delay, with distinct power-up and power-down latencies. It replaces fixed-depth shift-register delay chains and adds mid-ramp reversal handling, stall injection and per-domain status.

## Interface
Parameters:
- NUM_DOMAINS, 4: number of independent switch channels (>=1)
- ON_LATENCY, 15: cycles from sampled switch-on request to ack_n_o falling (>=1)
- OFF_LATENCY, 15: cycles from sampled switch-off request to ack_n_o rising (>=1)
- RESET_ON, 1'b1: 1 = every channel leaves reset powered (ack_n_o=0); 0 = unpowered (ack_n_o=1)

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_ni  in  1  asynchronous active-low reset
- switch_n_i  in  NUM_DOMAINS  per-domain switch request, active-low (0 = power on)
- stall_i  in  NUM_DOMAINS  per-domain fault injection; while 1 the ramp counter holds
- ack_n_o  out  NUM_DOMAINS  per-domain switch acknowledge, active-low, registered
- busy_o  out  NUM_DOMAINS  1 while channel is ramping (RAMP_ON/RAMP_OFF)
- abort_cnt_o  out  NUM_DOMAINS*8  per-domain saturating count of aborted ramps

Clocking is fixed: one clock, clk_i; reset is asynchronous, active-low, rst_ni.

## Operation
- Per-channel FSM states: OFF, RAMP_ON, ON, RAMP_OFF. Channels are fully independent.
- Reset: state = ON if RESET_ON else OFF; ack_n_o = ~RESET_ON; busy_o = 0; counter = 0; abort_cnt_o = 0.
- OFF, switch_n_i=0: go to RAMP_ON, counter <= ON_LATENCY-1.
- ON, switch_n_i=1: go to RAMP_OFF, counter <= OFF_LATENCY-1.
- RAMP_x, request unchanged, stall_i=0:
  - counter==0: enter the target stable state and toggle ack_n_o.
  - otherwise: counter decrements.
- RAMP_x, stall_i=1: counter holds, no state change. A request reversal still takes priority over the stall.
- RAMP_x, request reverts to the prior stable value: return to the prior stable state in that cycle. ack_n_o is unchanged and abort_cnt increments, saturating at 255.
- OFF or ON, request matches the state: idle. stall_i has no effect.
- Counter width is $clog2(max(ON_LATENCY,OFF_LATENCY)+1), computed in the package function.

## Timing
- switch_n_i changes before rising edge k, no stall: ack_n_o changes right after edge k+LAT, where LAT is ON_LATENCY or OFF_LATENCY. busy_o is high from edge k to edge k+LAT.
- LAT=1: busy_o is high for exactly one cycle.
- Each stall cycle extends the latency by exactly one cycle.
- A reversal sampled at edge j during a ramp clears busy_o after edge j. A new ramp can start at edge j+1 if the request toggles again.
- A request pulse shorter than one clock period that is not present at an edge is ignored.
- rst_ni asserted mid-ramp: outputs return to their reset values immediately (asynchronously); the ramp is lost.
- Outputs never glitch: they are registered and have no combinational path from the inputs.

## Structure
- pwr_switch_model_pkg: state enum sw_state_e {OFF, RAMP_ON, ON, RAMP_OFF}; function cnt_width(on,off); constant ABORT_CNT_W = 8.
- Sub-module pwr_switch_chan: one FSM, counter and abort counter. The top instantiates it NUM_DOMAINS times in a generate loop and concatenates the outputs.
- In the testharness the top drives the core_v_mini_mcu ack inputs, which removes the per-domain shift arrays.

## Test plan
- Reset release with RESET_ON=1, NUM_DOMAINS=4, switch_n_i=0 -> ack_n_o=4'b0000, busy_o=0, all abort counts 0.
- Channel 2 switch_n_i 0->1 before edge 100, OFF_LATENCY=15 -> ack_n_o[2] rises after edge 115, busy_o[2] high for edges 100..114; other channels unchanged.
- ON_LATENCY=3, OFF_LATENCY=7: off then on requests 20 cycles apart -> ack delays of exactly 7 and 3 cycles.
- stall_i[0] high for 5 cycles mid RAMP_ON with ON_LATENCY=15 -> ack_n_o[0] falls 20 cycles after the request.
- Request reverted 4 cycles into RAMP_OFF -> ack_n_o stays 0, busy_o drops, abort_cnt=1. After 300 such reversals -> abort_cnt saturates at 255.
- rst_ni pulsed low at cycle 8 of a 15-cycle RAMP_ON with RESET_ON=0 -> ack_n_o=1 and busy_o=0 immediately. After release, the still-low request restarts a full 15-cycle ramp.
